// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - decode-stage hazard detection, MDU busy tracking and stall control
//
// Ports:
//   Clk, Reset             rising-edge clock, synchronous active-high reset
//   D_rs, D_rt             source registers of the instruction in D
//   D_use_rs, D_use_rt     D instruction actually reads rs / rt
//   D_tuse_rs, D_tuse_rt   cycles until the D instruction needs rs / rt
//   D_is_md                D instruction touches the MDU or HI/LO
//   E_dst, M_dst           destination registers in E / M (0 = none)
//   E_tnew, M_tnew         cycles until the E / M result can be forwarded
//   E_md_start             E instruction starts the MDU this cycle
//   E_md_is_div            start is a divide (else multiply)
//   PC_en                  PC advances
//   FD_hold                F/D register holds
//   DE_clear               D/E register loads a bubble
//   md_busy                MDU countdown is running
//   stall_cycles           saturating count of stalled cycles

module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic             D_use_rs,
    input  logic             D_use_rt,
    input  logic [1:0]       D_tuse_rs,
    input  logic [1:0]       D_tuse_rt,
    input  logic             D_is_md,
    input  logic [4:0]       E_dst,
    input  logic [4:0]       M_dst,
    input  logic [1:0]       E_tnew,
    input  logic [1:0]       M_tnew,
    input  logic             E_md_start,
    input  logic             E_md_is_div,
    output logic             PC_en,
    output logic             FD_hold,
    output logic             DE_clear,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // Countdown must hold the longer of the two latencies, and is never narrower than 4 bits.
    localparam int MD_MAX  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MD_BITS = $clog2(MD_MAX + 1);
    localparam int MD_W    = (MD_BITS < 4) ? 4 : MD_BITS;

    localparam logic [MD_W-1:0] MD_LOAD_MULT = MD_W'(MULT_CYCLES);
    localparam logic [MD_W-1:0] MD_LOAD_DIV  = MD_W'(DIV_CYCLES);

    logic [MD_W-1:0] md_cnt;
    logic            rs_hazard;
    logic            rt_hazard;
    logic            md_hazard;
    logic            stall;

    // A source is hazardous when the producer in E or M will not have its result
    // forwardable by the time D needs it. Register 0 is hardwired and never waits.
    always_comb begin
        rs_hazard = D_use_rs && (D_rs != 5'd0) &&
                    (((D_rs == E_dst) && (E_tnew > D_tuse_rs)) ||
                     ((D_rs == M_dst) && (M_tnew > D_tuse_rs)));
        rt_hazard = D_use_rt && (D_rt != 5'd0) &&
                    (((D_rt == E_dst) && (E_tnew > D_tuse_rt)) ||
                     ((D_rt == M_dst) && (M_tnew > D_tuse_rt)));
        // The starter in E has not loaded the countdown yet, so it counts as busy too.
        md_hazard = D_is_md && (md_busy || E_md_start);
        stall     = rs_hazard || rt_hazard || md_hazard;
    end

    assign PC_en    = ~stall;
    assign FD_hold  = stall;
    assign DE_clear = stall;
    assign md_busy  = (md_cnt != '0);

    // A new start always reloads, even over a countdown already in progress.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            md_cnt <= '0;
        end else if (E_md_start) begin
            md_cnt <= E_md_is_div ? MD_LOAD_DIV : MD_LOAD_MULT;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    // Saturating: once all ones the counter holds rather than wrapping.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl with a cycle-index reference model
module tb_hazard_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int CW     = 4;
    localparam int SAT    = 15;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [4:0]    D_rs, D_rt, E_dst, M_dst;
    logic          D_use_rs, D_use_rt, D_is_md, E_md_start, E_md_is_div;
    logic [1:0]    D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic          PC_en, FD_hold, DE_clear, md_busy;
    logic [CW-1:0] stall_cycles;

    hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
        .E_dst(E_dst), .M_dst(M_dst), .E_tnew(E_tnew), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .PC_en(PC_en), .FD_hold(FD_hold), .DE_clear(DE_clear),
        .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int   cyc;
        logic stall;
        logic busy;
        int   cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the MDU window is the last cycle index it stays busy,
    // and the stall count is an unbounded integer clipped on readout.
    int   cyc      = 0;
    int   busy_end = -1;
    int   stall_n  = 0;

    task automatic clear_inputs();
        Reset = 1'b0; D_rs = '0; D_rt = '0; D_use_rs = 1'b0; D_use_rt = 1'b0;
        D_tuse_rs = '0; D_tuse_rt = '0; D_is_md = 1'b0; E_dst = '0; M_dst = '0;
        E_tnew = '0; M_tnew = '0; E_md_start = 1'b0; E_md_is_div = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
        clear_inputs();
    endtask

    function automatic bit src_waits(input logic use_r, input logic [4:0] r, input logic [1:0] tuse);
        bit w;
        w = 1'b0;
        if (use_r && r != 0) begin
            if (r == E_dst && int'(E_tnew) > int'(tuse)) w = 1'b1;
            if (r == M_dst && int'(M_tnew) > int'(tuse)) w = 1'b1;
        end
        return w;
    endfunction

    // Called once the current cycle's inputs are in place.
    task automatic commit();
        exp_t e;
        bit   busy;
        bit   st;
        busy = (cyc <= busy_end);
        st   = src_waits(D_use_rs, D_rs, D_tuse_rs) || src_waits(D_use_rt, D_rt, D_tuse_rt) ||
               (D_is_md && (busy || E_md_start));
        e.cyc   = cyc;
        e.stall = st;
        e.busy  = busy;
        e.cnt   = (stall_n > SAT) ? SAT : stall_n;
        sb.push_back(e);
        if (Reset) begin
            busy_end = cyc;
            stall_n  = 0;
        end else begin
            if (E_md_start) busy_end = cyc + (E_md_is_div ? DIV_N : MULT_N);
            if (st) stall_n++;
        end
        cyc++;
    endtask

    task automatic check(input string name, input int c, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, got, want);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare against the oldest expectation.
    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("PC_en",        e.cyc, int'(PC_en),        int'(!e.stall));
            check("FD_hold",      e.cyc, int'(FD_hold),      int'(e.stall));
            check("DE_clear",     e.cyc, int'(DE_clear),     int'(e.stall));
            check("md_busy",      e.cyc, int'(md_busy),      int'(e.busy));
            check("stall_cycles", e.cyc, int'(stall_cycles), e.cnt);
        end
    end

    initial begin
        clear_inputs();
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b1;
        commit();                                   // reset cycle itself

        // Reset state, quiet inputs
        next_cycle(); commit();

        // Load-use on rs: tuse 1 < tnew 2 stalls, tuse 2 does not
        next_cycle(); E_dst = 5'd8; E_tnew = 2'd2; D_use_rs = 1; D_rs = 5'd8; D_tuse_rs = 2'd1; commit();
        next_cycle(); E_dst = 5'd8; E_tnew = 2'd2; D_use_rs = 1; D_rs = 5'd8; D_tuse_rs = 2'd2; commit();

        // $0 never stalls; M-stage match on rt does
        next_cycle(); E_dst = 5'd0; E_tnew = 2'd2; D_rs = 5'd0; D_use_rs = 1; D_tuse_rs = 2'd0; commit();
        next_cycle(); M_dst = 5'd9; M_tnew = 2'd1; D_rt = 5'd9; D_tuse_rt = 2'd0; D_use_rt = 1; commit();

        // mult then mflo held in D
        next_cycle(); E_md_start = 1; E_md_is_div = 0; D_is_md = 1; commit();
        for (int i = 1; i <= 7; i++) begin
            next_cycle(); D_is_md = 1; commit();
        end

        // div with a non-MDU instruction in D: busy but no stall
        next_cycle(); E_md_start = 1; E_md_is_div = 1; commit();
        for (int i = 1; i <= 11; i++) begin
            next_cycle(); commit();
        end

        // Reset three cycles into a div countdown
        next_cycle(); E_md_start = 1; E_md_is_div = 1; commit();
        for (int i = 1; i <= 2; i++) begin
            next_cycle(); D_is_md = 1; commit();
        end
        next_cycle(); D_is_md = 1; Reset = 1; commit();
        for (int i = 0; i < 3; i++) begin
            next_cycle(); D_is_md = 1; commit();
        end

        // Saturation: hold a hazard 20 cycles
        for (int i = 0; i < 20; i++) begin
            next_cycle(); E_dst = 5'd3; E_tnew = 2'd1; D_use_rt = 1; D_rt = 5'd3; D_tuse_rt = 2'd0; commit();
        end
        next_cycle(); commit();

        // Randomized traffic over a small register set so matches are frequent
        for (int i = 0; i < 600; i++) begin
            next_cycle();
            Reset       = ($urandom_range(0, 99) < 2);
            D_rs        = 5'($urandom_range(0, 3));
            D_rt        = 5'($urandom_range(0, 3));
            D_use_rs    = 1'($urandom_range(0, 1));
            D_use_rt    = 1'($urandom_range(0, 1));
            D_tuse_rs   = 2'($urandom_range(0, 2));
            D_tuse_rt   = 2'($urandom_range(0, 2));
            D_is_md     = ($urandom_range(0, 3) == 0);
            E_dst       = 5'($urandom_range(0, 3));
            M_dst       = 5'($urandom_range(0, 3));
            E_tnew      = 2'($urandom_range(0, 3));
            M_tnew      = 2'($urandom_range(0, 3));
            E_md_start  = ($urandom_range(0, 9) == 0);
            E_md_is_div = 1'($urandom_range(0, 1));
            commit();
        end

        // Drain the scoreboard with a bounded wait
        begin
            int waited;
            waited = 0;
            while (sb.size() > 0 && waited < 10) begin
                @(posedge Clk);
                waited++;
            end
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
